// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier sequencer among NREQ requesters.
// Optional watchdog on the multiplier wait is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
  parameter int n       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] mcand_in,
  input  logic [NREQ*n-1:0] mplier_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*n-1:0]    product,
  output logic              err,
  output logic              mult_start,
  output logic [n-1:0]      mult_a,
  output logic [n-1:0]      mult_b,
  input  logic              mult_ready,
  input  logic [2*n-1:0]    mult_product
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT positive");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;

  state_t          state;
  logic [IW-1:0]   last_served;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW-1:0]   rr_idx;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt;
`endif

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    rr_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = IW'((32'(last_served) + k) % NREQ);
      if (!win_vld && req[rr_idx]) begin
        win     = rr_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      mult_start  <= 1'b0;
      product     <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      cur         <= '0;
      last_served <= IW'(NREQ - 1);
`ifdef MULT_ARB_TIMEOUT_EN
      err         <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt    <= NREQ'(1) << win;
            cur    <= win;
            mult_a <= mcand_in[win*n +: n];
            mult_b <= mplier_in[win*n +: n];
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          mult_start <= 1'b1;
          state      <= WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt        <= '0;
`endif
        end
        WAIT: begin
          mult_start <= 1'b0;
          // While the start strobe is still high the sequencer has not left
          // its stopped state yet, so mult_ready is stale and ignored.
          if (!mult_start && mult_ready) begin
            product    <= mult_product;
            done       <= gnt;
            mult_start <= 1'b1;
            state      <= RELEASE;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            product    <= '0;
            err        <= 1'b1;
            done       <= gnt;
            mult_start <= 1'b1;
            state      <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          done        <= '0;
          mult_start  <= 1'b0;
          gnt         <= '0;
          last_served <= cur;
`ifdef MULT_ARB_TIMEOUT_EN
          err         <= 1'b0;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULT_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized scoreboard bench for mult_arbiter with a behavioural multiplier sequencer
// and a round-robin reference model kept at transaction level.
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int NR  = 4;
  localparam int TMO = 64;

  logic            clock;
  logic            n_reset;
  logic [NR-1:0]   req;
  logic [NR*N-1:0] mcand_in, mplier_in;
  logic [NR-1:0]   gnt, done;
  logic [2*N-1:0]  product;
  logic            err, mult_start, mult_ready;
  logic [N-1:0]    mult_a, mult_b;
  logic [2*N-1:0]  mult_product;

  mult_arbiter #(.n(N), .NREQ(NR), .TIMEOUT(TMO)) dut (
    .clock(clock), .n_reset(n_reset), .req(req), .mcand_in(mcand_in),
    .mplier_in(mplier_in), .gnt(gnt), .done(done), .product(product),
    .err(err), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_ready(mult_ready), .mult_product(mult_product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int idx; logic [7:0] prod; bit tmo; } exp_t;
  exp_t sbq[$];

  int passed = 0, total = 0, ndone = 0, mcyc = 0;
  bit auto_req = 0, hold_all = 0, drop_en = 0, tmo_mode = 0, seq_stuck = 0;
  bit [NR-1:0] busy = '0;
  int seq_st = 0, seq_cnt = 0, seq_lat = 8;
  logic [N-1:0] sa, sb;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic req_set(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    mcand_in[i*N +: N]  = a;
    mplier_in[i*N +: N] = b;
    req[i]  = 1'b1;
    busy[i] = 1'b1;
  endtask

  // One clock: behavioural sequencer plus requester agents, driven #1 after posedge.
  task automatic step();
    logic s_start;
    logic [N-1:0] s_a, s_b;
    logic [NR-1:0] s_done, s_gnt;
    @(negedge clock);
    s_start = mult_start; s_a = mult_a; s_b = mult_b; s_done = done; s_gnt = gnt;
    @(posedge clock); #1;
    if (!n_reset) begin
      seq_st = 0; mult_ready = 1'b1;
    end else begin
      case (seq_st)
        0: if (s_start) begin
             seq_st = 1; seq_cnt = seq_lat; sa = s_a; sb = s_b;
             mult_ready = 1'b0; mult_product = 8'($urandom);
           end
        1: if (s_start) begin
             seq_st = 0; mult_ready = 1'b1;
           end else if (!seq_stuck) begin
             if (seq_cnt <= 1) begin
               seq_st = 2; mult_ready = 1'b1; mult_product = 8'(sa) * 8'(sb);
             end else seq_cnt--;
           end
        default: if (s_start) seq_st = 0;
      endcase
      for (int i = 0; i < NR; i++) begin
        if (s_done[i]) begin
          if (!hold_all) req[i] = 1'b0;
          busy[i] = 1'b0;
        end else if (auto_req && !req[i] && !busy[i] && $urandom_range(0, 3) == 0) begin
          req_set(i, 4'($urandom), 4'($urandom));
        end else if (drop_en && s_gnt[i] && req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        if (auto_req && s_gnt[i] && !s_done[i] && $urandom_range(0, 2) == 0) begin
          mcand_in[i*N +: N]  = 4'($urandom);
          mplier_in[i*N +: N] = 4'($urandom);
        end
      end
    end
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((req != 0 || gnt != 0 || busy != 0) && k < limit) begin step(); k++; end
    if (k >= limit) chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_gnt(input int limit);
    int k = 0;
    while (gnt == 0 && k < limit) begin step(); k++; end
    if (k >= limit) chk("grant_timeout", 1, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start"}, mult_start, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_product"}, product, 0);
    chk({tag, "_mult_a"}, mult_a, 0);
    chk({tag, "_mult_b"}, mult_b, 0);
  endtask

  // Monitor: reference arbitration model and scoreboard, sampled on negedge.
  initial begin
    int last = NR - 1, grant_cyc = 0, ready_cyc = 0, e;
    bit launch_chk = 0;
    logic [NR-1:0] pg = '0, pd = '0, prev_req = '0;
    logic pstart = 0, pready = 1;
    logic [NR*N-1:0] prev_mcand = '0, prev_mplier = '0;
    exp_t x;
    forever begin
      @(negedge clock);
      mcyc++;
      if (!n_reset) begin
        sbq.delete(); last = NR - 1; launch_chk = 0;
        pg = '0; pd = '0; pstart = 0; pready = 1; prev_req = req;
      end else begin
        if (mult_ready && !pready) ready_cyc = mcyc;
        if (gnt != 0 && pg == 0) begin
          e = -1;
          for (int k = 1; k <= NR; k++)
            if (e < 0 && prev_req[(last + k) % NR]) e = (last + k) % NR;
          if (e < 0) chk("grant_src", gnt, 0);
          else begin
            chk("grant", gnt, 1 << e);
            chk("mult_a", mult_a, prev_mcand[e*N +: N]);
            chk("mult_b", mult_b, prev_mplier[e*N +: N]);
            sbq.push_back('{e, 8'(prev_mcand[e*N +: N]) * 8'(prev_mplier[e*N +: N]), tmo_mode});
            grant_cyc = mcyc; launch_chk = 1;
          end
        end
        if (mult_start && !pstart && launch_chk) begin
          chk("launch_lat", mcyc - grant_cyc, 1);
          launch_chk = 0;
        end
        if (done != 0) begin
          ndone++;
          if (sbq.size() == 0) chk("done_unexpected", done, 0);
          else begin
            x = sbq.pop_front();
            chk("done", done, 1 << x.idx);
            chk("gnt_at_done", gnt, 1 << x.idx);
            chk("release_start", mult_start, 1);
            chk("product", product, x.tmo ? 0 : x.prod);
            chk("err", err, x.tmo ? 1 : 0);
            if (x.tmo) chk("timeout_lat", mcyc - grant_cyc, TMO + 1);
            else       chk("ready_to_done", mcyc - ready_cyc, 1);
            last = x.idx;
          end
        end
        if (pd != 0) chk("gnt_clear", gnt, 0);
        pg = gnt; pd = done; pstart = mult_start; pready = mult_ready;
        prev_req = req; prev_mcand = mcand_in; prev_mplier = mplier_in;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    req = '0; mcand_in = '0; mplier_in = '0; mult_ready = 1'b1; mult_product = '0;
    n_reset = 1'b1;
    #1 n_reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_zero("reset");
    n_reset = 1'b1;

    // All four held continuously: first five grants must run 0,1,2,3,0.
    hold_all = 1; seq_lat = 3;
    for (int i = 0; i < NR; i++) req_set(i, 4'($urandom), 4'($urandom));
    begin
      int k = 0;
      while (ndone < 5 && k < 300) begin step(); k++; end
      if (k >= 300) chk("hold_timeout", ndone, 5);
    end
    hold_all = 0;
    drain(300);

    // 5 x 3 with an 8-cycle multiplier.
    seq_lat = 8;
    req_set(0, 4'd5, 4'd3);
    step(); chk("d_gnt", gnt, 1);
    chk("d_start_c1", mult_start, 0);
    step(); chk("d_start_c2", mult_start, 1);
    drain(100);
    chk("d_product", product, 15);

    req_set(0, 4'd15, 4'd15);
    drain(100);
    chk("max_product", product, 225);

    // Requester 2 drops during WAIT; next grant must be requester 3.
    seq_lat = 6;
    req_set(2, 4'd6, 4'd7);
    wait_gnt(20);
    repeat (3) step();
    req[2] = 1'b0;
    req_set(0, 4'd2, 4'd9);
    req_set(3, 4'd11, 4'd13);
    drain(200);

    auto_req = 1; drop_en = 1;
    for (int c = 0; c < 1500; c++) begin
      seq_lat = $urandom_range(1, 10);
      step();
    end
    auto_req = 0; drop_en = 0;
    drain(400);

    // Asynchronous reset in the middle of WAIT.
    seq_lat = 20;
    req_set(2, 4'd9, 4'd14);
    wait_gnt(20);
    repeat (4) step();
    @(posedge clock); #3;
    n_reset = 1'b0;
    #1 check_zero("midreset");
    req = '0; busy = '0;
    repeat (2) step();
    n_reset = 1'b1;
    seq_lat = 5;
    req_set(1, 4'd7, 4'd9);
    step(); chk("post_reset_gnt", gnt, 4'b0010);
    drain(100);
    chk("post_reset_product", product, 63);

`ifdef MULT_ARB_TIMEOUT_EN
    seq_stuck = 1; tmo_mode = 1;
    req_set(1, 4'd3, 4'd3);
    drain(200);
    seq_stuck = 0; tmo_mode = 0;
    req_set(2, 4'd4, 4'd4);
    drain(100);
    chk("after_timeout_product", product, 16);
`endif

    repeat (3) step();
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
